// File: rtl/switch_matrix_cfg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : switch_matrix_cfg_if
// Purpose  : Config/readback port bundle for the routing switch matrix.
// Revision : 1.0 - initial release
// ============================================================================
interface switch_matrix_cfg_if #(
    parameter int SEL_W = 5
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_addr;
    logic [SEL_W-1:0] cfg_sel;
    logic             cfg_commit;
    logic             cfg_done;
    logic             cfg_dirty;
    logic             cfg_err;
    logic             cfg_err_clr;
    logic [SEL_W-1:0] rd_addr;
    logic [SEL_W-1:0] rd_sel;

    modport master (
        output cfg_valid, cfg_addr, cfg_sel, cfg_commit, cfg_err_clr, rd_addr,
        input  cfg_ready, cfg_done, cfg_dirty, cfg_err, rd_sel
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_sel, cfg_commit, cfg_err_clr, rd_addr,
        output cfg_ready, cfg_done, cfg_dirty, cfg_err, rd_sel
    );
endinterface
`default_nettype wire

// File: rtl/switch_matrix_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : switch_matrix_cfg
// Purpose  : Runtime-configurable routing matrix with shadow/active banks and
//            atomic commit; outputs are combinational from the active bank.
// Revision : 1.0 - initial release
// ============================================================================
module switch_matrix_cfg #(
    parameter int NUM_WIRES = 18,
    parameter int SEL_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    switch_matrix_cfg_if.slave   cfg,
    input  logic [NUM_WIRES-1:0] wire_in,
    output logic [NUM_WIRES-1:0] wire_out,
    output logic [NUM_WIRES-1:0] wire_oe
);

    generate
        if ((2 ** SEL_W) <= NUM_WIRES) begin : g_bad_params
            $error("switch_matrix_cfg: SEL_W too narrow for NUM_WIRES");
        end
    endgenerate

    localparam logic [SEL_W-1:0] C_MAX_WIRE = SEL_W'(NUM_WIRES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Wire a lives at index a; index 0 is never used since 0 means "off".
    logic [SEL_W-1:0] r_active [NUM_WIRES:1];
    logic [SEL_W-1:0] r_shadow [NUM_WIRES:1];

    logic             r_done;
    logic             r_err;

    logic             w_ready;
    logic             w_wr_req;
    logic             w_wr_legal;
    logic             w_wr_ok;
    logic             w_wr_bad;
    logic             w_commit;

    // ------------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------------
    assign w_ready    = (r_state != ST_SWAP);
    assign w_wr_req   = cfg.cfg_valid & w_ready;
    assign w_commit   = cfg.cfg_commit & w_ready;

    assign w_wr_legal = (cfg.cfg_addr != '0)
                      && (cfg.cfg_addr <= C_MAX_WIRE)
                      && (cfg.cfg_sel  <= C_MAX_WIRE)
                      && (cfg.cfg_sel  != cfg.cfg_addr);

    assign w_wr_ok    = w_wr_req &  w_wr_legal;
    assign w_wr_bad   = w_wr_req & ~w_wr_legal;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_commit) begin
                    w_state_nxt = ST_SWAP;
                end else if (w_wr_ok) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_commit) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shadow and active banks. A write sampled together with a commit lands
    // in the shadow at that edge, so the following SWAP copies it across.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 1; a <= NUM_WIRES; a++) begin
                r_shadow[a] <= '0;
                r_active[a] <= '0;
            end
        end else begin
            for (int a = 1; a <= NUM_WIRES; a++) begin
                if (w_wr_ok && (cfg.cfg_addr == SEL_W'(a))) begin
                    r_shadow[a] <= cfg.cfg_sel;
                end
                if (r_state == ST_SWAP) begin
                    r_active[a] <= r_shadow[a];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_state == ST_SWAP);
            if (w_wr_bad) begin
                r_err <= 1'b1;
            end else if (cfg.cfg_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign cfg.cfg_ready = w_ready;
    assign cfg.cfg_done  = r_done;
    assign cfg.cfg_dirty = (r_state == ST_ARMED);
    assign cfg.cfg_err   = r_err;

    // ------------------------------------------------------------------------
    // Readback of the active bank
    // ------------------------------------------------------------------------
    always_comb begin
        cfg.rd_sel = '0;
        for (int a = 1; a <= NUM_WIRES; a++) begin
            if (cfg.rd_addr == SEL_W'(a)) begin
                cfg.rd_sel = r_active[a];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Routing datapath: one-hot decode of each selector masks wire_in.
    // ------------------------------------------------------------------------
    genvar g_dst;
    genvar g_src;
    generate
        for (g_dst = 1; g_dst <= NUM_WIRES; g_dst++) begin : g_route
            logic [NUM_WIRES-1:0] w_match;

            for (g_src = 1; g_src <= NUM_WIRES; g_src++) begin : g_match
                assign w_match[g_src-1] = (r_active[g_dst] == SEL_W'(g_src));
            end

            assign wire_oe[g_dst-1]  = (r_active[g_dst] != '0);
            assign wire_out[g_dst-1] = |(w_match & wire_in);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_switch_matrix_cfg.sv
`timescale 1ns/1ps
// Directed bench for switch_matrix_cfg: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_switch_matrix_cfg;

    localparam int NUM_WIRES = 18;
    localparam int SEL_W     = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_WIRES-1:0] wire_in;
    logic [NUM_WIRES-1:0] wire_out;
    logic [NUM_WIRES-1:0] wire_oe;

    int tests_run    = 0;
    int tests_failed = 0;

    switch_matrix_cfg_if #(.SEL_W(SEL_W)) cfg_bus ();

    switch_matrix_cfg #(
        .NUM_WIRES (NUM_WIRES),
        .SEL_W     (SEL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg      (cfg_bus),
        .wire_in  (wire_in),
        .wire_out (wire_out),
        .wire_oe  (wire_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_bus.cfg_valid   = 1'b0;
        cfg_bus.cfg_addr    = '0;
        cfg_bus.cfg_sel     = '0;
        cfg_bus.cfg_commit  = 1'b0;
        cfg_bus.cfg_err_clr = 1'b0;
        cfg_bus.rd_addr     = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] s);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_sel   = s;
        tick();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        cfg_bus.cfg_commit = 1'b1;
        tick();
        cfg_bus.cfg_commit = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        wire_in = NUM_WIRES'($urandom);
        cfg_bus.rd_addr = 5'd10;
        #1;
        tests_run++;
        if (wire_oe !== 18'h0) begin
            tests_failed++; $display("FAIL reset_oe: got %h want %h", wire_oe, 18'h0);
        end
        tests_run++;
        if (wire_out !== 18'h0) begin
            tests_failed++; $display("FAIL reset_out: got %h want %h", wire_out, 18'h0);
        end
        tests_run++;
        if (cfg_bus.cfg_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: got %b want 1", cfg_bus.cfg_ready);
        end
        tests_run++;
        if (cfg_bus.rd_sel !== 5'd0) begin
            tests_failed++; $display("FAIL reset_rd_sel: got %0d want 0", cfg_bus.rd_sel);
        end
        tests_run++;
        if ({cfg_bus.cfg_done, cfg_bus.cfg_dirty, cfg_bus.cfg_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 000",
                     {cfg_bus.cfg_done, cfg_bus.cfg_dirty, cfg_bus.cfg_err});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_route_commit();
        wire_in = '0;
        do_write(5'd10, 5'd7);
        tests_run++;
        if (cfg_bus.cfg_dirty !== 1'b1 || wire_oe !== 18'h0) begin
            tests_failed++;
            $display("FAIL route_pending: dirty=%b oe=%h want dirty=1 oe=0", cfg_bus.cfg_dirty, wire_oe);
        end
        do_commit();
        tests_run++;
        if (cfg_bus.cfg_ready !== 1'b0 || cfg_bus.cfg_done !== 1'b0 || wire_oe !== 18'h0) begin
            tests_failed++;
            $display("FAIL route_swap: ready=%b done=%b oe=%h want 0 0 0",
                     cfg_bus.cfg_ready, cfg_bus.cfg_done, wire_oe);
        end
        tick();
        cfg_bus.rd_addr = 5'd10;
        #1;
        tests_run++;
        if (wire_oe !== 18'h00200 || cfg_bus.cfg_done !== 1'b1 || cfg_bus.cfg_dirty !== 1'b0) begin
            tests_failed++;
            $display("FAIL route_applied: oe=%h done=%b dirty=%b want 00200 1 0",
                     wire_oe, cfg_bus.cfg_done, cfg_bus.cfg_dirty);
        end
        tests_run++;
        if (cfg_bus.rd_sel !== 5'd7) begin
            tests_failed++; $display("FAIL route_rd_sel: got %0d want 7", cfg_bus.rd_sel);
        end
        wire_in = 18'h00040;
        #1;
        tests_run++;
        if (wire_out !== 18'h00200) begin
            tests_failed++; $display("FAIL route_track_hi: got %h want 00200", wire_out);
        end
        wire_in = 18'h3FFBF;
        #1;
        tests_run++;
        if (wire_out !== 18'h00000) begin
            tests_failed++; $display("FAIL route_track_lo: got %h want 00000", wire_out);
        end
        tick();
        tests_run++;
        if (cfg_bus.cfg_done !== 1'b0) begin
            tests_failed++; $display("FAIL route_done_once: got %b want 0", cfg_bus.cfg_done);
        end
        cfg_bus.rd_addr = 5'd0;
        #1;
        tests_run++;
        if (cfg_bus.rd_sel !== 5'd0) begin
            tests_failed++; $display("FAIL rd_addr0: got %0d want 0", cfg_bus.rd_sel);
        end
        cfg_bus.rd_addr = 5'd31;
        #1;
        tests_run++;
        if (cfg_bus.rd_sel !== 5'd0) begin
            tests_failed++; $display("FAIL rd_addr31: got %0d want 0", cfg_bus.rd_sel);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reject();
        apply_reset();
        wire_in = 18'h3FFFF;
        do_write(5'd3, 5'd19);
        tests_run++;
        if (cfg_bus.cfg_err !== 1'b1 || cfg_bus.cfg_dirty !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_sel_range: err=%b dirty=%b want 1 0", cfg_bus.cfg_err, cfg_bus.cfg_dirty);
        end
        do_write(5'd0, 5'd1);
        do_write(5'd5, 5'd5);
        do_write(5'd19, 5'd2);
        tests_run++;
        if (cfg_bus.cfg_err !== 1'b1 || cfg_bus.cfg_dirty !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_others: err=%b dirty=%b want 1 0", cfg_bus.cfg_err, cfg_bus.cfg_dirty);
        end
        do_commit();
        tests_run++;
        if (cfg_bus.cfg_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reject_idle_swap: ready=%b want 0", cfg_bus.cfg_ready);
        end
        tick();
        cfg_bus.rd_addr = 5'd5;
        #1;
        tests_run++;
        if (wire_oe !== 18'h0 || wire_out !== 18'h0 || cfg_bus.cfg_done !== 1'b1 || cfg_bus.rd_sel !== 5'd0) begin
            tests_failed++;
            $display("FAIL reject_commit: oe=%h out=%h done=%b rd=%0d want 0 0 1 0",
                     wire_oe, wire_out, cfg_bus.cfg_done, cfg_bus.rd_sel);
        end
        cfg_bus.cfg_err_clr = 1'b1;
        tick();
        cfg_bus.cfg_err_clr = 1'b0;
        tests_run++;
        if (cfg_bus.cfg_err !== 1'b0) begin
            tests_failed++; $display("FAIL err_clear: got %b want 0", cfg_bus.cfg_err);
        end
        cfg_bus.cfg_err_clr = 1'b1;
        do_write(5'd0, 5'd0);
        cfg_bus.cfg_err_clr = 1'b0;
        tests_run++;
        if (cfg_bus.cfg_err !== 1'b1) begin
            tests_failed++; $display("FAIL err_set_wins: got %b want 1", cfg_bus.cfg_err);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_pending_overwrite();
        bit leaked;
        apply_reset();
        wire_in = 18'h3FFFF;
        do_write(5'd4, 5'd2);
        tests_run++;
        if (cfg_bus.cfg_dirty !== 1'b1 || cfg_bus.cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_dirty: dirty=%b err=%b want 1 0", cfg_bus.cfg_dirty, cfg_bus.cfg_err);
        end
        leaked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wire_oe[3] !== 1'b0) leaked = 1'b1;
            tick();
        end
        tests_run++;
        if (leaked !== 1'b0) begin
            tests_failed++; $display("FAIL pend_no_leak: oe[4] rose without commit (got 1 want 0)");
        end
        do_write(5'd4, 5'd9);
        do_commit();
        tick();
        cfg_bus.rd_addr = 5'd4;
        wire_in = 18'h00100;
        #1;
        tests_run++;
        if (cfg_bus.rd_sel !== 5'd9 || wire_oe !== 18'h00008) begin
            tests_failed++;
            $display("FAIL overwrite_sel: rd=%0d oe=%h want 9 00008", cfg_bus.rd_sel, wire_oe);
        end
        tests_run++;
        if (wire_out !== 18'h00008) begin
            tests_failed++; $display("FAIL overwrite_hi: got %h want 00008", wire_out);
        end
        wire_in = 18'h00002;
        #1;
        tests_run++;
        if (wire_out !== 18'h00000) begin
            tests_failed++; $display("FAIL overwrite_old_src: got %h want 00000", wire_out);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        apply_reset();
        wire_in = 18'h00001;
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_addr   = 5'd12;
        cfg_bus.cfg_sel    = 5'd1;
        cfg_bus.cfg_commit = 1'b1;
        tick();
        cfg_bus.cfg_commit = 1'b0;
        cfg_bus.cfg_addr   = 5'd13;
        cfg_bus.cfg_sel    = 5'd2;
        tests_run++;
        if (cfg_bus.cfg_ready !== 1'b0 || wire_oe !== 18'h0) begin
            tests_failed++;
            $display("FAIL b2b_swap: ready=%b oe=%h want 0 0", cfg_bus.cfg_ready, wire_oe);
        end
        tick();
        tests_run++;
        if (cfg_bus.cfg_ready !== 1'b1 || cfg_bus.cfg_done !== 1'b1 || wire_oe !== 18'h00800
            || wire_out !== 18'h00800 || cfg_bus.cfg_dirty !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_applied: ready=%b done=%b oe=%h out=%h dirty=%b want 1 1 00800 00800 0",
                     cfg_bus.cfg_ready, cfg_bus.cfg_done, wire_oe, wire_out, cfg_bus.cfg_dirty);
        end
        tick();
        cfg_bus.cfg_valid = 1'b0;
        tests_run++;
        if (cfg_bus.cfg_dirty !== 1'b1 || wire_oe !== 18'h00800) begin
            tests_failed++;
            $display("FAIL b2b_held_write: dirty=%b oe=%h want 1 00800", cfg_bus.cfg_dirty, wire_oe);
        end
        do_commit();
        tick();
        tests_run++;
        if (wire_oe !== 18'h01800) begin
            tests_failed++; $display("FAIL b2b_second: oe=%h want 01800", wire_oe);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_swap();
        bit seen_done;
        bit nonzero_rd;
        wire_in = 18'h3FFFF;
        do_write(5'd6, 5'd8);
        do_commit();
        tests_run++;
        if (cfg_bus.cfg_ready !== 1'b0) begin
            tests_failed++; $display("FAIL midswap_in_swap: ready=%b want 0", cfg_bus.cfg_ready);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (wire_oe !== 18'h0 || wire_out !== 18'h0 || cfg_bus.cfg_done !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midswap_reset: oe=%h out=%h done=%b ready=%b want 0 0 0 1",
                     wire_oe, wire_out, cfg_bus.cfg_done, cfg_bus.cfg_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cfg_bus.cfg_done !== 1'b0) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done !== 1'b0) begin
            tests_failed++; $display("FAIL midswap_no_done: got done=1 want 0");
        end
        nonzero_rd = 1'b0;
        for (int a = 0; a < 32; a++) begin
            cfg_bus.rd_addr = SEL_W'(a);
            #1;
            if (cfg_bus.rd_sel !== 5'd0) nonzero_rd = 1'b1;
        end
        tests_run++;
        if (nonzero_rd !== 1'b0 || wire_oe !== 18'h0 || cfg_bus.cfg_dirty !== 1'b0) begin
            tests_failed++;
            $display("FAIL midswap_cleared: rd_nonzero=%b oe=%h dirty=%b want 0 0 0",
                     nonzero_rd, wire_oe, cfg_bus.cfg_dirty);
        end
    endtask

    initial begin
        test_reset();
        test_route_commit();
        test_reject();
        test_pending_overwrite();
        test_back_to_back();
        test_reset_mid_swap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

endmodule
